elastic_register: RTL and testbench
===================================

Name: elastic_register

Overview:
- Two-entry valid/ready pipeline register (skid buffer). It is the handshaked counterpart of the plain free-running pipeline register.
- The producer writes words in; the consumer reads them out under backpressure.
- Sits between pipeline stages or between the core and memory-side logic where the downstream stage can stall.
- Fully registered in both directions: no combinational path from i_read_ready to o_write_ready, or from i_write_data to o_read_data.

Parameters:
- DATA_WIDTH, 32, width of the data word carried.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- arst  input  1  reset, synchronous, active-high.
- i_flush  input  1  synchronous flush; discards all held words.
- i_write_valid  input  1  producer presents a word.
- i_write_data  input  DATA_WIDTH  producer word.
- o_write_ready  output  1  block can accept a word this cycle; registered.
- o_read_valid  output  1  o_read_data holds a valid word; registered.
- o_read_data  output  DATA_WIDTH  oldest held word; registered.
- i_read_ready  input  1  consumer takes the word this cycle.
- o_count  output  2  number of words held (0..2).

Behaviour:
- Reset (arst=1 at a rising edge):
  - state EMPTY; o_read_valid=0; o_write_ready=1; o_count=0.
  - main and skid data registers cleared to 0, so o_read_data=0.
  - Reset overrides flush and all handshakes. A reset mid-transfer drops every held word.
- Handshake terms:
  - accept = i_write_valid & o_write_ready.
  - take = o_read_valid & i_read_ready.
  - i_write_data is ignored unless accept. Data is never lost or duplicated. Order is strictly FIFO.
- State machine, sampled on the rising edge:
  - EMPTY (count 0, o_read_valid=0, o_write_ready=1):
    - accept -> BUSY; main <= i_write_data.
    - otherwise stay.
  - BUSY (count 1, o_read_valid=1, o_write_ready=1):
    - accept & take -> BUSY; main <= i_write_data.
    - accept & !take -> FULL; skid <= i_write_data; main unchanged.
    - !accept & take -> EMPTY.
    - neither -> hold.
  - FULL (count 2, o_read_valid=1, o_write_ready=0):
    - take -> BUSY; main <= skid.
    - no take -> hold.
    - i_write_valid is ignored in FULL.
- Outputs:
  - o_read_data is always driven from the main register.
  - o_write_ready = (next state != FULL), registered.
  - o_read_valid = (next state != EMPTY), registered.
  - o_count is registered and always consistent with state.
- Latency:
  - A word accepted into EMPTY appears on o_read_valid/o_read_data the next cycle.
  - Sustained throughput is 1 word/cycle when i_read_ready is held high.
- Flush (i_flush=1, arst=0):
  - Next state EMPTY; o_read_valid=0; o_write_ready=1; o_count=0.
  - Any accept or take in the same cycle is void: the word is dropped and not counted.
  - Data registers keep their contents; they are not observable while o_read_valid=0.
- Stability:
  - While o_read_valid=1 and i_read_ready=0, o_read_data holds steady until take or flush.
- Illegal encodings: an unused state encoding recovers to EMPTY on the next edge.

Test Plan:
- Reset then single word:
  - Stimulus: arst high 2 cycles; send 0xDEADBEEF with i_read_ready=1.
  - Required: o_read_valid=1 and o_read_data=0xDEADBEEF exactly 1 cycle after accept; o_count 0->1->0.
- Streaming:
  - Stimulus: 8 back-to-back words 0x1..0x8 with i_read_ready=1.
  - Required: o_write_ready stays 1; outputs 0x1..0x8 in order on consecutive cycles.
- Backpressure fill:
  - Stimulus: i_read_ready=0; offer 0xA, 0xB, 0xC.
  - Required: 0xA and 0xB accepted; o_count=2; o_write_ready=0; 0xC held off; o_read_data stays 0xA.
  - Then release i_read_ready: order out is 0xA, 0xB, 0xC.
- Simultaneous accept and take in BUSY:
  - Stimulus: hold 0x5; same cycle take it and accept 0x6.
  - Required: o_count stays 1; o_read_data=0x6 next cycle.
- Flush in FULL with a concurrent take:
  - Required: next cycle o_read_valid=0, o_count=0, o_write_ready=1.
  - Next accepted word 0x77 is the first word out.
- Reset mid-operation in FULL with i_write_valid=1:
  - Required: next cycle o_read_valid=0, o_read_data=0, o_count=0, o_write_ready=1.

Source files
------------

// File: rtl/elastic_register.sv
// elastic_register: two-entry valid/ready skid buffer.
// The consumer always reads the main register. The skid register catches the
// one word that arrives while the consumer stalls with main already occupied.
// Every output comes straight from a flop, so neither i_read_ready nor
// i_write_data has a combinational path to an output.
module elastic_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_flush,
  input  logic                  i_write_valid,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic                  o_write_ready,
  output logic                  o_read_valid,
  output logic [DATA_WIDTH-1:0] o_read_data,
  input  logic                  i_read_ready,
  output logic [1:0]            o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  wr_rdy_q, wr_rdy_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [1:0]            count_q, count_d;

  logic accept;
  logic take;

  assign accept = i_write_valid & wr_rdy_q;
  assign take   = rd_vld_q & i_read_ready;

  // Next-state, data steering and registered-output precomputation.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = BUSY;
          main_d  = i_write_data;
        end
      end
      BUSY: begin
        if (accept && take) begin
          main_d = i_write_data;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = i_write_data;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        // The unused encoding recovers to EMPTY.
        state_d = EMPTY;
      end
    endcase

    // A flush empties the buffer and voids any handshake in the same cycle.
    // The data registers keep their old contents, which cannot be seen while
    // the buffer is empty.
    if (i_flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    // Each output flag is computed from the next state so that it can leave
    // the block directly from a flop.
    wr_rdy_d = (state_d != FULL);
    rd_vld_d = (state_d != EMPTY);
    unique case (state_d)
      BUSY:    count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  // State, data and output registers. Reset takes priority over flush and over
  // every handshake.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      wr_rdy_q <= 1'b1;
      rd_vld_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      wr_rdy_q <= wr_rdy_d;
      rd_vld_q <= rd_vld_d;
      count_q  <= count_d;
    end
  end

  assign o_write_ready = wr_rdy_q;
  assign o_read_valid  = rd_vld_q;
  assign o_read_data   = main_q;
  assign o_count       = count_q;

endmodule

// File: tb/tb_elastic_register.sv
// Testbench for elastic_register.
// Part one applies a table of per-cycle vectors. Each row is checked one
// cycle later against its expected flags, count and, optionally, data.
// Part two is a randomised stream. A queue model records every accepted word
// and checks each word the consumer takes for both order and value.
module tb_elastic_register;

  localparam int DW = 32;

  logic          clk;
  logic          arst;
  logic          i_flush;
  logic          i_write_valid;
  logic [DW-1:0] i_write_data;
  logic          o_write_ready;
  logic          o_read_valid;
  logic [DW-1:0] o_read_data;
  logic          i_read_ready;
  logic [1:0]    o_count;

  elastic_register #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .arst         (arst),
    .i_flush      (i_flush),
    .i_write_valid(i_write_valid),
    .i_write_data (i_write_data),
    .o_write_ready(o_write_ready),
    .o_read_valid (o_read_valid),
    .o_read_data  (o_read_data),
    .i_read_ready (i_read_ready),
    .o_count      (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue model: words that have been accepted but not yet taken.
  logic [DW-1:0] sb_q[$];

  // Before the DUT's flops update on each edge, retire the taken word and
  // record the accepted one. Reset and flush empty the model.
  always @(posedge clk) begin
    if (arst || i_flush) begin
      sb_q.delete();
    end else begin
      if (o_read_valid && i_read_ready) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: take with no expected word, got 0x%0h at %0t", o_read_data, $time);
        end else begin
          chk("sb_data", o_read_data, sb_q.pop_front());
        end
      end
      if (i_write_valid && o_write_ready) sb_q.push_back(i_write_data);
    end
  end

  typedef struct {
    logic          rst;
    logic          fl;
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          erv;
    logic          ewr;
    logic [1:0]    ecnt;
    logic          chkd;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic fl, input logic wv, input logic [DW-1:0] wd,
                     input logic rr, input logic erv, input logic ewr, input logic [1:0] ecnt,
                     input logic chkd, input logic [DW-1:0] ed);
    vec_t v;
    v.rst = rst; v.fl = fl; v.wv = wv; v.wd = wd; v.rr = rr;
    v.erv = erv; v.ewr = ewr; v.ecnt = ecnt; v.chkd = chkd; v.ed = ed;
    vt.push_back(v);
  endtask

  initial begin
    arst = 1'b1; i_flush = 1'b0; i_write_valid = 1'b0; i_write_data = '0; i_read_ready = 1'b0;

    // Fields: rst fl wv wd rr | read_valid write_ready count check_data data
    // Reset for two cycles.
    add(1,0,0,32'h0,0,        0,1,2'd0,1,32'h0);
    add(1,0,0,32'h0,0,        0,1,2'd0,1,32'h0);
    // Single word: visible one cycle after accept, then count returns to 0.
    add(0,0,1,32'hDEADBEEF,1, 1,1,2'd1,1,32'hDEADBEEF);
    add(0,0,0,32'h0,1,        0,1,2'd0,0,32'h0);
    // Streaming: eight words back to back with the consumer always ready.
    for (int i = 1; i <= 8; i++) add(0,0,1,DW'(i),1, 1,1,2'd1,1,DW'(i));
    add(0,0,0,32'h0,1,        0,1,2'd0,0,32'h0);
    // Backpressure: 0xA and 0xB fill the buffer and 0xC is held off.
    add(0,0,1,32'hA,0,        1,1,2'd1,1,32'hA);
    add(0,0,1,32'hB,0,        1,0,2'd2,1,32'hA);
    add(0,0,1,32'hC,0,        1,0,2'd2,1,32'hA);
    add(0,0,1,32'hC,1,        1,1,2'd1,1,32'hB);
    add(0,0,1,32'hC,1,        1,1,2'd1,1,32'hC);
    add(0,0,0,32'h0,1,        0,1,2'd0,0,32'h0);
    // Accept and take in the same BUSY cycle.
    add(0,0,1,32'h5,0,        1,1,2'd1,1,32'h5);
    add(0,0,1,32'h6,1,        1,1,2'd1,1,32'h6);
    add(0,0,0,32'h0,1,        0,1,2'd0,0,32'h0);
    // Flush in FULL with a take in the same cycle; 0x77 is the next word out.
    add(0,0,1,32'h11,0,       1,1,2'd1,1,32'h11);
    add(0,0,1,32'h22,0,       1,0,2'd2,1,32'h11);
    add(0,1,1,32'h33,1,       0,1,2'd0,0,32'h0);
    add(0,0,1,32'h77,0,       1,1,2'd1,1,32'h77);
    add(0,0,0,32'h0,1,        0,1,2'd0,0,32'h0);
    // Flush in BUSY with an accept and a take in the same cycle: both are void.
    add(0,0,1,32'h44,0,       1,1,2'd1,1,32'h44);
    add(0,1,1,32'h55,1,       0,1,2'd0,0,32'h0);
    add(0,0,1,32'h66,1,       1,1,2'd1,1,32'h66);
    add(0,0,0,32'h0,1,        0,1,2'd0,0,32'h0);
    // Reset in FULL while a write is offered.
    add(0,0,1,32'h91,0,       1,1,2'd1,1,32'h91);
    add(0,0,1,32'h92,0,       1,0,2'd2,1,32'h91);
    add(1,0,1,32'h93,1,       0,1,2'd0,1,32'h0);
    add(0,0,1,32'hAB,1,       1,1,2'd1,1,32'hAB);
    add(0,0,0,32'h0,1,        0,1,2'd0,0,32'h0);

    foreach (vt[i]) begin
      arst          = vt[i].rst;
      i_flush       = vt[i].fl;
      i_write_valid = vt[i].wv;
      i_write_data  = vt[i].wd;
      i_read_ready  = vt[i].rr;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_read_valid", i),  DW'(o_read_valid),  DW'(vt[i].erv));
      chk($sformatf("v%0d_write_ready", i), DW'(o_write_ready), DW'(vt[i].ewr));
      chk($sformatf("v%0d_count", i),       DW'(o_count),       DW'(vt[i].ecnt));
      if (vt[i].chkd) chk($sformatf("v%0d_data", i), o_read_data, vt[i].ed);
    end

    // Randomised stream with occasional flushes. The queue model checks every
    // taken word, and the flags must track the model's occupancy.
    arst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      i_write_valid = 1'($urandom_range(0, 1));
      i_write_data  = $urandom;
      i_read_ready  = 1'($urandom_range(0, 2) != 0);
      i_flush       = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
      chk("rnd_count",       DW'(o_count),       DW'(sb_q.size()));
      chk("rnd_read_valid",  DW'(o_read_valid),  DW'(sb_q.size() != 0));
      chk("rnd_write_ready", DW'(o_write_ready), DW'(sb_q.size() != 2));
      if (sb_q.size() != 0) chk("rnd_head", o_read_data, sb_q[0]);
    end

    // Drain whatever is still held so the last words are also checked in order.
    i_write_valid = 1'b0;
    i_flush       = 1'b0;
    i_read_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_count", DW'(o_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
